// File: rtl/omp_frame_scheduler.sv
`default_nettype none
// omp_frame_scheduler: packs SPI measurement bytes into a ping-pong buffer and
// hands each completed frame to the OMP solver through a start/done handshake.
module omp_frame_scheduler #(
  parameter int N_MEAS = 64,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_frame_start,
  input  logic              rx_frame_end,
  output logic              buf_we,
  output logic [IDX_W:0]    buf_waddr,
  output logic [DATA_W-1:0] buf_wdata,
  output logic              solver_start,
  output logic              solver_bank,
  input  logic              solver_done,
  output logic              busy,
  output logic              overrun,
  output logic              len_err,
  input  logic              err_clr,
  output logic [15:0]       frame_count
);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_DROP = 2'd2
  } wstate_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } sstate_t;

  wstate_t           w_state, w_state_nxt;
  sstate_t           s_state, s_state_nxt;
  logic [1:0]        full, full_set, full_clr;
  logic              wb, wb_nxt;
  logic              rb, rb_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic              drop_long, drop_long_nxt;
  logic              we_nxt;
  logic [IDX_W:0]    waddr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic              start_nxt;
  logic              bank_nxt;
  logic [15:0]       count_nxt;
  logic              set_overrun, set_len_err;
  logic              done_run, bank_free, last_byte;

  assign done_run  = (s_state == S_RUN) && solver_done;
  // A bank released by the solver in this very cycle may be claimed at once.
  assign bank_free = !full[wb] || (done_run && (rb == wb));
  assign last_byte = (idx == IDX_W'(N_MEAS - 1));
  assign busy      = (w_state == W_FILL) || (s_state == S_RUN);

  // Write side: frame framing, byte packing and error detection.
  always_comb begin
    w_state_nxt   = w_state;
    idx_nxt       = idx;
    wb_nxt        = wb;
    drop_long_nxt = drop_long;
    we_nxt        = 1'b0;
    waddr_nxt     = {wb, idx};
    wdata_nxt     = rx_data;
    set_overrun   = 1'b0;
    set_len_err   = 1'b0;
    full_set      = 2'b00;
    case (w_state)
      W_IDLE: begin
        if (rx_frame_start) begin
          if (bank_free) begin
            idx_nxt     = '0;
            w_state_nxt = W_FILL;
          end else begin
            set_overrun   = 1'b1;
            drop_long_nxt = 1'b0;
            w_state_nxt   = W_DROP;
          end
        end
      end
      W_FILL: begin
        if (rx_frame_start) begin
          idx_nxt     = '0;
          set_len_err = 1'b1;
        end else begin
          if (rx_valid) begin
            we_nxt  = 1'b1;
            idx_nxt = idx + 1'b1;
            if (last_byte) begin
              full_set      = wb ? 2'b10 : 2'b01;
              wb_nxt        = !wb;
              drop_long_nxt = 1'b1;
              w_state_nxt   = W_DROP;
            end
          end
          // Frame end is evaluated after any byte arriving in the same cycle.
          if (rx_frame_end) begin
            w_state_nxt = W_IDLE;
            if (!(rx_valid && last_byte)) begin
              set_len_err = 1'b1;
              idx_nxt     = '0;
            end
          end
        end
      end
      W_DROP: begin
        if (rx_valid && drop_long) set_len_err = 1'b1;
        if (rx_frame_end) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Solver side: with the other bank already full, the next start is chained
  // directly off solver_done so back-to-back runs lose only one cycle.
  always_comb begin
    s_state_nxt = s_state;
    rb_nxt      = rb;
    start_nxt   = 1'b0;
    bank_nxt    = solver_bank;
    full_clr    = 2'b00;
    count_nxt   = frame_count;
    case (s_state)
      S_IDLE: begin
        if (full[rb]) begin
          start_nxt   = 1'b1;
          bank_nxt    = rb;
          s_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (solver_done) begin
          full_clr  = rb ? 2'b10 : 2'b01;
          rb_nxt    = !rb;
          count_nxt = frame_count + 16'd1;
          if (full[!rb]) begin
            start_nxt = 1'b1;
            bank_nxt  = !rb;
          end else begin
            s_state_nxt = S_IDLE;
          end
        end
      end
      default: s_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state      <= W_IDLE;
      s_state      <= S_IDLE;
      full         <= 2'b00;
      wb           <= 1'b0;
      rb           <= 1'b0;
      idx          <= '0;
      drop_long    <= 1'b0;
      buf_we       <= 1'b0;
      buf_waddr    <= '0;
      buf_wdata    <= '0;
      solver_start <= 1'b0;
      solver_bank  <= 1'b0;
      overrun      <= 1'b0;
      len_err      <= 1'b0;
      frame_count  <= 16'd0;
    end else begin
      w_state      <= w_state_nxt;
      s_state      <= s_state_nxt;
      full         <= (full & ~full_clr) | full_set;
      wb           <= wb_nxt;
      rb           <= rb_nxt;
      idx          <= idx_nxt;
      drop_long    <= drop_long_nxt;
      buf_we       <= we_nxt;
      buf_waddr    <= waddr_nxt;
      buf_wdata    <= wdata_nxt;
      solver_start <= start_nxt;
      solver_bank  <= bank_nxt;
      // A new error event outranks a simultaneous clear.
      overrun      <= (overrun & ~err_clr) | set_overrun;
      len_err      <= (len_err & ~err_clr) | set_len_err;
      frame_count  <= count_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_omp_frame_scheduler.sv
`default_nettype none
// Directed self-checking bench for omp_frame_scheduler.
module tb_omp_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst, rx_valid, rx_frame_start, rx_frame_end, solver_done, err_clr;
  logic [7:0]  rx_data;
  logic        buf_we;
  logic [6:0]  buf_waddr;
  logic [7:0]  buf_wdata;
  logic        solver_start, solver_bank, busy, overrun, len_err;
  logic [15:0] frame_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wr_addr[$];
  int wr_data[$];
  int last_we_cyc = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int start_bank = 0;

  omp_frame_scheduler #(.N_MEAS(64), .DATA_W(8), .IDX_W(6)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_frame_start(rx_frame_start), .rx_frame_end(rx_frame_end),
    .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
    .solver_start(solver_start), .solver_bank(solver_bank), .solver_done(solver_done),
    .busy(busy), .overrun(overrun), .len_err(len_err), .err_clr(err_clr),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (buf_we) begin
      wr_addr.push_back(int'(buf_waddr));
      wr_data.push_back(int'(buf_wdata));
      last_we_cyc = cyc;
    end
    if (solver_start) begin
      start_cnt++;
      start_cyc  = cyc;
      start_bank = int'(solver_bank);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    start_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_log();
  endtask

  task automatic fstart();
    rx_frame_start = 1'b1;
    tick();
    rx_frame_start = 1'b0;
  endtask

  task automatic fend();
    rx_frame_end = 1'b1;
    tick();
    rx_frame_end = 1'b0;
  endtask

  task automatic send_bytes(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'(base + i);
      tick();
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int base, input int n);
    fstart();
    send_bytes(base, n);
    fend();
    tick();
  endtask

  task automatic pulse_done(output int edge_c);
    solver_done = 1'b1;
    tick();
    solver_done = 1'b0;
    edge_c = cyc;
  endtask

  // Checks the logged writes against {bank, i} / base+i, then empties the log.
  task automatic chk_frame(input string tag, input int bank, input int base, input int n);
    int bad;
    bad = 0;
    chk({tag, "_wr_count"}, wr_addr.size(), n);
    for (int i = 0; i < wr_addr.size() && i < n; i++) begin
      if (wr_addr[i] != bank * 64 + i || wr_data[i] != ((base + i) & 255)) bad++;
    end
    chk({tag, "_wr_bad_entries"}, bad, 0);
    wr_addr.delete();
    wr_data.delete();
  endtask

  initial begin
    int e;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_frame_start = 1'b0;
    rx_frame_end = 1'b0; solver_done = 1'b0; err_clr = 1'b0;
    tick();
    tick();
    chk("reset_flags", {buf_we, solver_start, solver_bank, busy, overrun, len_err}, 0);
    chk("reset_count", frame_count, 0);
    rst = 1'b0;
    tick();
    clear_log();

    // 1: single frame, start one cycle after last write, done bumps count
    send_frame(0, 64);
    chk_frame("t1", 0, 0, 64);
    chk("t1_start_cnt", start_cnt, 1);
    chk("t1_start_bank", start_bank, 0);
    chk("t1_start_latency", start_cyc - last_we_cyc, 1);
    chk("t1_busy_run", busy, 1);
    pulse_done(e);
    tick();
    chk("t1_frame_count", frame_count, 1);
    chk("t1_busy_idle", busy, 0);
    chk("t1_no_extra_start", start_cnt, 1);

    // 2: two frames with solver held busy on bank 0
    do_reset();
    send_frame(8'h10, 64);
    chk_frame("t2a", 0, 8'h10, 64);
    chk("t2a_start_bank", start_bank, 0);
    send_frame(8'h40, 64);
    chk_frame("t2b", 1, 8'h40, 64);
    chk("t2b_held_start_cnt", start_cnt, 1);

    // 3: both banks full -> overrun; then done coincident with frame start
    send_frame(8'h80, 64);
    chk("t3_drop_writes", wr_addr.size(), 0);
    chk("t3_overrun", overrun, 1);
    chk("t3_no_len_err", len_err, 0);
    rx_frame_start = 1'b1;
    solver_done    = 1'b1;
    tick();
    rx_frame_start = 1'b0;
    solver_done    = 1'b0;
    e = cyc;
    send_bytes(8'h20, 64);
    fend();
    tick();
    chk_frame("t3_accept", 0, 8'h20, 64);
    chk("t3_overrun_kept", overrun, 1);
    chk("t2_b2b_start_cnt", start_cnt, 2);
    chk("t2_b2b_start_bank", start_bank, 1);
    chk("t2_b2b_latency", start_cyc - e, 0);
    pulse_done(e);
    tick();
    chk("t3_chain_start_cnt", start_cnt, 3);
    chk("t3_chain_bank", start_bank, 0);
    chk("t3_chain_latency", start_cyc - e, 0);
    pulse_done(e);
    tick();
    chk("t3_frame_count", frame_count, 3);
    chk("t3_busy_idle", busy, 0);

    // 4: short frame, then full frame rewrites bank 0 from index 0
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_overrun_clr", overrun, 0);
    do_reset();
    send_frame(0, 10);
    chk_frame("t4_short", 0, 0, 10);
    chk("t4_len_err", len_err, 1);
    chk("t4_no_start", start_cnt, 0);
    chk("t4_busy", busy, 0);
    send_frame(8'h50, 64);
    chk_frame("t4_full", 0, 8'h50, 64);
    chk("t4_start_cnt", start_cnt, 1);
    chk("t4_start_bank", start_bank, 0);
    pulse_done(e);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_len_err_clr", len_err, 0);

    // 5: 70-byte frame into bank 1; error wins over simultaneous clear
    clear_log();
    fstart();
    send_bytes(8'h60, 64);
    rx_valid = 1'b1;
    rx_data  = 8'hEE;
    err_clr  = 1'b1;
    tick();
    err_clr  = 1'b0;
    rx_valid = 1'b0;
    chk("t5_set_beats_clr", len_err, 1);
    send_bytes(8'hF0, 5);
    fend();
    tick();
    chk_frame("t5", 1, 8'h60, 64);
    chk("t5_len_err", len_err, 1);
    chk("t5_start_cnt", start_cnt, 1);
    chk("t5_start_bank", start_bank, 1);

    // 6: reset mid-frame while solver runs; stray done and bytes ignored
    chk("t6_busy_before", busy, 1);
    fstart();
    send_bytes(0, 29);
    rst      = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'd29;
    tick();
    rst      = 1'b0;
    rx_valid = 1'b0;
    chk("t6_reset_flags", {buf_we, solver_start, solver_bank, busy, overrun, len_err}, 0);
    chk("t6_reset_count", frame_count, 0);
    clear_log();
    pulse_done(e);
    send_bytes(8'h33, 3);
    tick();
    tick();
    chk("t6_count_after_done", frame_count, 0);
    chk("t6_no_start", start_cnt, 0);
    chk("t6_idle_bytes_ignored", wr_addr.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
